// File: rtl/pipe_scroll_ctrl.sv
// Flappy Bird game-state producer: two scrolling pipe pairs with LFSR gap heights,
// bird/pipe/ground collision, score counting and the IDLE/RUN/OVER game FSM.
module pipe_scroll_ctrl #(
  parameter int unsigned PIPE_W   = 60,
  parameter int unsigned GAP      = 120,
  parameter int unsigned BIRD_X   = 100,
  parameter int unsigned BIRD_W   = 34,
  parameter int unsigned BIRD_H   = 24,
  parameter int unsigned GROUND_Y = 440
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] bird_y,
  output logic [9:0] pipe1_x,
  output logic [9:0] pipe2_x,
  output logic [9:0] up_pipe1_y,
  output logic [9:0] up_pipe2_y,
  output logic [9:0] down_pipe1_y,
  output logic [9:0] down_pipe2_y,
  output logic       gameover,
  output logic       running,
  output logic [9:0] score,
  output logic       score_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [9:0]  X_SPAWN   = 10'd409;
  localparam logic [9:0]  P1_X0     = 10'd409;
  localparam logic [9:0]  P1_UP0    = 10'd140;
  localparam logic [9:0]  P1_DN0    = 10'd260;
  localparam logic [9:0]  P2_X0     = 10'd614;
  localparam logic [9:0]  P2_UP0    = 10'd200;
  localparam logic [9:0]  P2_DN0    = 10'd320;
  localparam logic [9:0]  SCORE_MAX = 10'd999;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [9:0]  BIRD_X10  = 10'(BIRD_X);
  localparam logic [10:0] BIRD_X11  = 11'(BIRD_X);
  // x - PIPE_W + 1 <= BIRD_X + BIRD_W - 1 rearranged so nothing is subtracted from x
  localparam logic [10:0] OVL_HI    = 11'(BIRD_X + BIRD_W + PIPE_W - 2);

  state_t      state;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [9:0]  spawn_up;
  logic [9:0]  spawn_down;
  logic        ground_hit;
  logic        collide;

  function automatic logic pipe_hit(input logic [9:0] x, input logic [9:0] up,
                                    input logic [9:0] down, input logic [9:0] by);
    logic overlap;
    overlap = ({1'b0, x} >= BIRD_X11) && ({1'b0, x} <= OVL_HI);
    return overlap && ((by <= up) || (({1'b0, by} + 11'(BIRD_H - 1)) >= {1'b0, down}));
  endfunction

  always_comb begin
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    spawn_up   = 10'(40) + {2'b00, lfsr[7:0]};
    spawn_down = spawn_up + 10'(GAP);
    ground_hit = ({1'b0, bird_y} + 11'(BIRD_H)) >= 11'(GROUND_Y);
    collide    = ground_hit
               || pipe_hit(pipe1_x, up_pipe1_y, down_pipe1_y, bird_y)
               || pipe_hit(pipe2_x, up_pipe2_y, down_pipe2_y, bird_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      pipe1_x      <= P1_X0;
      up_pipe1_y   <= P1_UP0;
      down_pipe1_y <= P1_DN0;
      pipe2_x      <= P2_X0;
      up_pipe2_y   <= P2_UP0;
      down_pipe2_y <= P2_DN0;
      score        <= '0;
      score_pulse  <= 1'b0;
      gameover     <= 1'b0;
      running      <= 1'b0;
    end else begin
      lfsr        <= {lfsr[14:0], lfsr_fb};
      score_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (collide) begin
            state    <= OVER;
            running  <= 1'b0;
            gameover <= 1'b1;
          end else if (tick) begin
            if (pipe1_x == '0) begin
              pipe1_x      <= X_SPAWN;
              up_pipe1_y   <= spawn_up;
              down_pipe1_y <= spawn_down;
            end else begin
              pipe1_x <= pipe1_x - 10'd1;
            end
            if (pipe2_x == '0) begin
              pipe2_x      <= X_SPAWN;
              up_pipe2_y   <= spawn_up;
              down_pipe2_y <= spawn_down;
            end else begin
              pipe2_x <= pipe2_x - 10'd1;
            end
            if ((pipe1_x == BIRD_X10) || (pipe2_x == BIRD_X10)) begin
              score_pulse <= 1'b1;
              if (score != SCORE_MAX) score <= score + 10'd1;
            end
          end
        end
        OVER: begin
          if (start) begin
            state        <= IDLE;
            gameover     <= 1'b0;
            pipe1_x      <= P1_X0;
            up_pipe1_y   <= P1_UP0;
            down_pipe1_y <= P1_DN0;
            pipe2_x      <= P2_X0;
            up_pipe2_y   <= P2_UP0;
            down_pipe2_y <= P2_DN0;
            score        <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_scroll_ctrl.sv
// Directed bench for pipe_scroll_ctrl: reset, scroll, score, respawn,
// LFSR repeatability after reset, pipe and ground collision, restart.
module tb_pipe_scroll_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic [9:0] bird_y;
  logic [9:0] pipe1_x, pipe2_x;
  logic [9:0] up_pipe1_y, up_pipe2_y, down_pipe1_y, down_pipe2_y;
  logic       gameover, running, score_pulse;
  logic [9:0] score;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [9:0]  up_a, down_a;

  pipe_scroll_ctrl #(
    .PIPE_W(60), .GAP(120), .BIRD_X(100), .BIRD_W(34), .BIRD_H(24), .GROUND_Y(440)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .bird_y(bird_y),
    .pipe1_x(pipe1_x), .pipe2_x(pipe2_x),
    .up_pipe1_y(up_pipe1_y), .up_pipe2_y(up_pipe2_y),
    .down_pipe1_y(down_pipe1_y), .down_pipe2_y(down_pipe2_y),
    .gameover(gameover), .running(running), .score(score), .score_pulse(score_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string ph);
    chk({ph, " pipe1_x"}, 32'(pipe1_x), 409);
    chk({ph, " up1"}, 32'(up_pipe1_y), 140);
    chk({ph, " down1"}, 32'(down_pipe1_y), 260);
    chk({ph, " pipe2_x"}, 32'(pipe2_x), 614);
    chk({ph, " up2"}, 32'(up_pipe2_y), 200);
    chk({ph, " down2"}, 32'(down_pipe2_y), 320);
    chk({ph, " score"}, 32'(score), 0);
    chk({ph, " pulse"}, 32'(score_pulse), 0);
    chk({ph, " gameover"}, 32'(gameover), 0);
    chk({ph, " running"}, 32'(running), 0);
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic release_run();
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; bird_y = 10'd200;
    repeat (3) @(negedge clk);
    chk_reset("por");

    // Run 1: scroll, score boundary, first respawn
    release_run();
    chk("running after start", 32'(running), 1);
    do_tick(10);
    chk("scroll pipe1_x", 32'(pipe1_x), 399);
    chk("scroll pipe2_x", 32'(pipe2_x), 604);
    chk("scroll score", 32'(score), 0);
    chk("scroll gameover", 32'(gameover), 0);
    do_tick(298);
    chk("pre-score pipe1_x", 32'(pipe1_x), 101);
    do_tick(1);
    chk("101->100 pipe1_x", 32'(pipe1_x), 100);
    chk("101->100 pulse", 32'(score_pulse), 0);
    chk("101->100 score", 32'(score), 0);
    do_tick(1);
    chk("100->99 pipe1_x", 32'(pipe1_x), 99);
    chk("100->99 pulse", 32'(score_pulse), 1);
    chk("100->99 score", 32'(score), 1);
    do_tick(1);
    chk("99->98 pulse", 32'(score_pulse), 0);
    chk("99->98 score", 32'(score), 1);
    do_tick(98);
    chk("pre-spawn pipe1_x", 32'(pipe1_x), 0);
    chk("pre-spawn pipe2_x", 32'(pipe2_x), 205);
    do_tick(1);
    chk("spawn pipe1_x", 32'(pipe1_x), 409);
    chk("spawn pipe2_x", 32'(pipe2_x), 204);
    chk("spawn up1 range", 32'((up_pipe1_y >= 10'd40) && (up_pipe1_y <= 10'd295)), 1);
    chk("spawn down1", 32'(down_pipe1_y), 32'(up_pipe1_y) + 120);
    chk("spawn running", 32'(running), 1);
    up_a   = up_pipe1_y;
    down_a = down_pipe1_y;

    // Run 2: asynchronous reset mid-run at pipe1_x=300
    rst_n = 1'b0;
    @(negedge clk);
    release_run();
    do_tick(109);
    chk("mid pipe1_x", 32'(pipe1_x), 300);
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    @(negedge clk);

    // Run 3: identical timing from reset, so the respawn repeats
    release_run();
    do_tick(410);
    chk("repeat pipe1_x", 32'(pipe1_x), 409);
    chk("repeat pipe2_x", 32'(pipe2_x), 204);
    chk("repeat up1", 32'(up_pipe1_y), 32'(up_a));
    chk("repeat down1", 32'(down_pipe1_y), 32'(down_a));

    // Run 4: pipe collision at pipe1_x=120 coinciding with a tick
    rst_n = 1'b0;
    @(negedge clk);
    release_run();
    do_tick(289);
    chk("pre-hit pipe1_x", 32'(pipe1_x), 120);
    chk("pre-hit pipe2_x", 32'(pipe2_x), 325);
    bird_y = 10'd130;
    do_tick(1);
    chk("hit gameover", 32'(gameover), 1);
    chk("hit running", 32'(running), 0);
    chk("hit no scroll", 32'(pipe1_x), 120);
    do_tick(3);
    chk("frozen pipe1_x", 32'(pipe1_x), 120);
    chk("frozen pipe2_x", 32'(pipe2_x), 325);
    chk("frozen score", 32'(score), 0);
    chk("frozen gameover", 32'(gameover), 1);

    // Restart, start+tick together in IDLE, ground boundary
    bird_y = 10'd200;
    pulse_start();
    chk_reset("restart");
    start = 1'b1; tick = 1'b1;
    @(negedge clk);
    start = 1'b0; tick = 1'b0;
    chk("start+tick running", 32'(running), 1);
    chk("start+tick no scroll", 32'(pipe1_x), 409);
    pulse_start();
    chk("start in run running", 32'(running), 1);
    chk("start in run gameover", 32'(gameover), 0);
    bird_y = 10'd415;
    do_tick(2);
    chk("y415 running", 32'(running), 1);
    chk("y415 pipe1_x", 32'(pipe1_x), 407);
    bird_y = 10'd416;
    @(negedge clk);
    chk("y416 gameover", 32'(gameover), 1);
    chk("y416 running", 32'(running), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_scroll_ctrl.md
# pipe_scroll_ctrl

Game-state producer for the Flappy Bird play field. Owns the two scrolling pipe pairs, including horizontal position and randomized gap heights. Detects bird/pipe/ground collision, counts score and drives the `gameover` flag. Its outputs feed the background/pipe pixel combiner directly, and that combiner's drawing conventions are the contract here. Geometry conventions:

- Pipe columns: `pipe*_x` is the pipe's right edge. A pipe occupies h in (x−60, x].
- Pipe rows: the up pipe occupies v ≤ up_y; the down pipe occupies v ≥ down_y.
- Play field: h < 350, v < 440.

## Interface
- `PIPE_W`, 60, pipe width in pixels.
- `GAP`, 120, vertical gap, down_y − up_y.
- `BIRD_X`, 100, bird left column (fixed).
- `BIRD_W`, 34, bird width.
- `BIRD_H`, 24, bird height.
- `GROUND_Y`, 440, first ground row.
- `clk` in 1 — system clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `tick` in 1 — one-cycle scroll strobe (frame rate).
- `start` in 1 — one-cycle start/restart request.
- `bird_y` in 10 — bird top row, stable between ticks.
- `pipe1_x`, `pipe2_x` out 10 — pipe right edges.
- `up_pipe1_y`, `up_pipe2_y` out 10 — last row of upper pipe.
- `down_pipe1_y`, `down_pipe2_y` out 10 — first row of lower pipe.
- `gameover` out 1 — high in OVER state.
- `running` out 1 — high in RUN state.
- `score` out 10 — pipes passed, binary, saturates at 999.
- `score_pulse` out 1 — one-cycle pulse per point.

## Operation
- **FSM states:** IDLE, RUN and OVER. All outputs are registered.
  - IDLE → RUN on `start`.
  - RUN → OVER on collision.
  - OVER → IDLE on `start`.
  - Entering IDLE loads the reset positions (below) and clears `score`.
- **Reset / IDLE values:**
  - `pipe1_x`=409, `up_pipe1_y`=140, `down_pipe1_y`=260.
  - `pipe2_x`=614, `up_pipe2_y`=200, `down_pipe2_y`=320.
  - `score`=0, `score_pulse`=0, `gameover`=0, `running`=0.
  - LFSR=16'hACE1.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Advances every clock in all states. Reset is the only reseed.
- **Scroll:**
  - In RUN, on `tick`, each pipe x decrements by 1.
  - A pipe with x==0 on a tick respawns instead: x=409, up_y=40+lfsr[7:0] (range 40..295), down_y=up_y+GAP.
  - Both pipes sample the same LFSR value if they respawn on the same tick, which cannot occur at the 205-pixel spacing.
  - The pipes stay 205 apart forever (410-value cycle).
- **Score:**
  - A tick that moves a pipe's x from BIRD_X to BIRD_X−1 (pipe fully left of the bird) increments `score` (saturating at 999).
  - The same tick asserts `score_pulse` for one cycle.
- **Collision:** combinational on registered state, acted on at the next edge in RUN. Collision is true when either:
  - bird_y+BIRD_H ≥ GROUND_Y; or
  - for either pipe, the column ranges overlap (x ≥ BIRD_X and x−PIPE_W+1 ≤ BIRD_X+BIRD_W−1, computed with 11-bit signed-safe arithmetic, no underflow when x<PIPE_W), and either bird_y ≤ up_y or bird_y+BIRD_H−1 ≥ down_y.
- **OVER:** positions and score are frozen. `tick` is ignored.
- **Width rules:** all sums are computed in 11 bits before compare. `down_y` always fits in 10 bits.

## Timing
- `tick` in RUN → positions update on the next edge, so outputs change 1 cycle after the strobe.
- `start` in IDLE → `running`=1 the next cycle. The first scroll happens on the first `tick` after that.
- Collision true in RUN → `gameover`=1, `running`=0 the next cycle. When `tick` and collision coincide, collision wins and no scroll or score occurs.
- `start` in RUN is ignored. `start` in OVER → IDLE values are visible the next cycle.
- `start` and `tick` in the same IDLE cycle → RUN entered and no scroll that cycle.
- `rst_n` low in any state → immediate asynchronous return to reset values. On release, the block waits for `start`.
- `score_pulse` is never high for more than 1 consecutive cycle.

## Test plan
- **Reset:** drop `rst_n` mid-RUN at pipe1_x=300 → all outputs immediately equal reset values; LFSR restarts at ACE1, so the respawn sequence repeats.
- **Scroll:** `start`, bird_y=200, 10 ticks → pipe1_x=399, pipe2_x=604, `score`=0, `gameover`=0.
- **Respawn:** run until pipe1_x=0, then one tick → pipe1_x=409, up_pipe1_y in 40..295, down_pipe1_y=up+120, pipe2_x=204.
- **Score:** track bird_y inside each gap; pipe1 tick 101→100 gives no pulse; tick 100→99 gives `score_pulse`=1 for 1 cycle and `score`=1.
- **Collision:**
  - At pipe1_x=120, bird_y=130 (≤140) → `gameover`=1 next cycle and positions freeze across further ticks.
  - bird_y=416 anywhere → ground collision.
- **Restart:** `start` in OVER → IDLE values, `score`=0; a second `start` → RUN.
